verifla_capture_sequencer: RTL and testbench

- Run controller that sits between the host command decoder, the logic-analyzer capture monitor and the capture sender.
- Issues the capture run request and supervises arm/trigger progress with a trigger timeout.
- Answers the monitor's send-capture handshake (sc_run / ack_sc_run / sc_done) and hands readout to the sender.
- Supports single-shot and continuous (auto re-arm with holdoff) capture, plus abort via a pulsed monitor clear.

---
 rtl/verifla_capture_sequencer.sv | 163 ++++++++++++++++
 tb/tb_verifla_capture_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/verifla_capture_sequencer.sv
// Capture run controller: issues run requests to the monitor, supervises arm/trigger
// with a timeout, answers the send-capture handshake and hands readout to the sender.
module verifla_capture_sequencer #(
  parameter int TIMEOUT_BITS = 24,
  parameter int HOLDOFF_BITS = 16,
  parameter int CLEAR_CYCLES = 4,
  parameter int COUNT_BITS   = 16
) (
  input  logic                    clk,
  input  logic                    rst_l,
  input  logic                    cmd_start,
  input  logic                    cmd_abort,
  input  logic                    cmd_continuous,
  input  logic [TIMEOUT_BITS-1:0] cfg_timeout,
  input  logic [HOLDOFF_BITS-1:0] cfg_holdoff,
  output logic                    mon_run,
  output logic                    mon_clear_l,
  input  logic                    mon_armed,
  input  logic                    mon_triggered,
  input  logic                    mon_sc_run,
  output logic                    mon_ack_sc_run,
  output logic                    mon_sc_done,
  output logic                    snd_start,
  input  logic                    snd_done,
  output logic                    busy,
  output logic                    timeout_flag,
  output logic [COUNT_BITS-1:0]   capture_count,
  output logic [3:0]              seq_state
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RUN       = 4'd1,
    WAIT_ARM  = 4'd2,
    WAIT_TRIG = 4'd3,
    WAIT_SC   = 4'd4,
    ACK       = 4'd5,
    SEND      = 4'd6,
    DONE      = 4'd7,
    HOLDOFF   = 4'd8,
    CLEAR     = 4'd9
  } state_t;

  localparam logic [3:0]              CLR_LEN  = 4'(CLEAR_CYCLES);
  localparam logic [3:0]              CLR_ONE  = 4'd1;
  localparam logic [TIMEOUT_BITS-1:0] TMO_ONE  = TIMEOUT_BITS'(1);
  localparam logic [HOLDOFF_BITS-1:0] HOLD_ONE = HOLDOFF_BITS'(1);
  localparam logic [COUNT_BITS-1:0]   CNT_ONE  = COUNT_BITS'(1);

  state_t                  state_q, state_d;
  logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
  logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
  logic [3:0]              clr_q, clr_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic                    tflag_q, tflag_d;
  logic                    run_q, clear_l_q, ack_q, done_q, snd_q, busy_q;

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    clr_d   = clr_q;
    count_d = count_q;
    tflag_d = tflag_q;
    case (state_q)
      IDLE: begin
        if (cmd_start) begin
          state_d = RUN;
          tflag_d = 1'b0;
        end
      end
      RUN: state_d = WAIT_ARM;
      WAIT_ARM: begin
        if (mon_armed) begin
          state_d = WAIT_TRIG;
          tmo_d   = '0;
        end
      end
      WAIT_TRIG: begin
        if (tmo_q != '1) tmo_d = tmo_q + TMO_ONE;
        // Trigger wins over a timeout landing in the same cycle.
        if (mon_triggered) begin
          state_d = WAIT_SC;
        end else if (cfg_timeout != '0 && tmo_q == cfg_timeout - TMO_ONE) begin
          state_d = CLEAR;
          clr_d   = '0;
          tflag_d = 1'b1;
        end
      end
      WAIT_SC: if (mon_sc_run) state_d = ACK;
      ACK:     if (!mon_sc_run) state_d = SEND;
      SEND:    if (snd_done) state_d = DONE;
      DONE: begin
        if (!mon_armed) begin
          count_d = count_q + CNT_ONE;
          if (cmd_continuous) begin
            state_d = HOLDOFF;
            hold_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HOLDOFF: begin
        if (hold_q == cfg_holdoff) state_d = RUN;
        else if (hold_q != '1)     hold_d  = hold_q + HOLD_ONE;
      end
      CLEAR: begin
        if (clr_q == CLR_LEN) state_d = IDLE;
        else                  clr_d   = clr_q + CLR_ONE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides every other update, and in CLEAR restarts the clear count.
    if (cmd_abort && state_q != IDLE) begin
      state_d = CLEAR;
      clr_d   = '0;
      count_d = count_q;
      tflag_d = tflag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      hold_q    <= '0;
      clr_q     <= '0;
      count_q   <= '0;
      tflag_q   <= 1'b0;
      run_q     <= 1'b0;
      clear_l_q <= 1'b1;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      snd_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      clr_q     <= clr_d;
      count_q   <= count_d;
      tflag_q   <= tflag_d;
      run_q     <= (state_d == RUN);
      clear_l_q <= !(state_d == CLEAR && clr_d < CLR_LEN);
      ack_q     <= (state_d == ACK);
      done_q    <= (state_d == DONE);
      snd_q     <= (state_q == ACK && state_d == SEND);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign mon_run        = run_q;
  assign mon_clear_l    = clear_l_q;
  assign mon_ack_sc_run = ack_q;
  assign mon_sc_done    = done_q;
  assign snd_start      = snd_q;
  assign busy           = busy_q;
  assign timeout_flag   = tflag_q;
  assign capture_count  = count_q;
  assign seq_state      = state_q;

endmodule

// File: tb/tb_verifla_capture_sequencer.sv
// Directed bench for verifla_capture_sequencer: single shot, timeout, trigger/timeout race,
// abort in SEND, asynchronous reset and continuous capture with holdoff.
module tb_verifla_capture_sequencer;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        cmd_start = 1'b0, cmd_abort = 1'b0, cmd_continuous = 1'b0;
  logic [23:0] cfg_timeout = '0;
  logic [15:0] cfg_holdoff = '0;
  logic        mon_run, mon_clear_l, mon_ack_sc_run, mon_sc_done, snd_start;
  logic        mon_armed = 1'b0, mon_triggered = 1'b0, mon_sc_run = 1'b0, snd_done = 1'b0;
  logic        busy, timeout_flag;
  logic [15:0] capture_count;
  logic [3:0]  seq_state;

  int compared = 0;
  int mismatched = 0;

  verifla_capture_sequencer dut (
    .clk(clk), .rst_l(rst_l),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort), .cmd_continuous(cmd_continuous),
    .cfg_timeout(cfg_timeout), .cfg_holdoff(cfg_holdoff),
    .mon_run(mon_run), .mon_clear_l(mon_clear_l), .mon_armed(mon_armed),
    .mon_triggered(mon_triggered), .mon_sc_run(mon_sc_run),
    .mon_ack_sc_run(mon_ack_sc_run), .mon_sc_done(mon_sc_done),
    .snd_start(snd_start), .snd_done(snd_done),
    .busy(busy), .timeout_flag(timeout_flag),
    .capture_count(capture_count), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete capture starting from the RUN cycle; ends just after the DONE exit edge.
  task automatic applyStimulus();
    tick();
    mon_armed = 1'b1;
    tick();
    mon_triggered = 1'b1;
    tick();
    mon_triggered = 1'b0;
    mon_sc_run = 1'b1;
    tick();
    mon_sc_run = 1'b0;
    tick();
    snd_done = 1'b1;
    tick();
    snd_done = 1'b0;
    checkOutput("cont_done", {31'd0, mon_sc_done}, 32'd1);
    mon_armed = 1'b0;
    tick();
  endtask

  initial begin
    #12;
    checkOutput("rst_state", {28'd0, seq_state}, 32'd0);
    checkOutput("rst_clear_l", {31'd0, mon_clear_l}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_count", {16'd0, capture_count}, 32'd0);
    rst_l = 1'b1;
    tick();

    // Single shot, no timeout
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checkOutput("ss_run_state", {28'd0, seq_state}, 32'd1);
    checkOutput("ss_mon_run", {31'd0, mon_run}, 32'd1);
    checkOutput("ss_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("ss_run_once", {31'd0, mon_run}, 32'd0);
    checkOutput("ss_wait_arm", {28'd0, seq_state}, 32'd2);
    tick();
    mon_armed = 1'b1;
    tick();
    checkOutput("ss_wait_trig", {28'd0, seq_state}, 32'd3);
    repeat (16) tick();
    checkOutput("ss_no_timeout", {28'd0, seq_state}, 32'd3);
    mon_triggered = 1'b1;
    tick();
    mon_triggered = 1'b0;
    checkOutput("ss_wait_sc", {28'd0, seq_state}, 32'd4);
    repeat (19) tick();
    checkOutput("ss_no_ack_yet", {31'd0, mon_ack_sc_run}, 32'd0);
    mon_sc_run = 1'b1;
    tick();
    checkOutput("ss_ack_state", {28'd0, seq_state}, 32'd5);
    tick();
    checkOutput("ss_ack_held", {31'd0, mon_ack_sc_run}, 32'd1);
    checkOutput("ss_no_snd_yet", {31'd0, snd_start}, 32'd0);
    mon_sc_run = 1'b0;
    tick();
    checkOutput("ss_send_state", {28'd0, seq_state}, 32'd6);
    checkOutput("ss_ack_drop", {31'd0, mon_ack_sc_run}, 32'd0);
    checkOutput("ss_snd_start", {31'd0, snd_start}, 32'd1);
    tick();
    checkOutput("ss_snd_pulse", {31'd0, snd_start}, 32'd0);
    repeat (8) tick();
    snd_done = 1'b1;
    tick();
    snd_done = 1'b0;
    checkOutput("ss_done_state", {28'd0, seq_state}, 32'd7);
    checkOutput("ss_sc_done", {31'd0, mon_sc_done}, 32'd1);
    tick();
    checkOutput("ss_sc_done_held", {31'd0, mon_sc_done}, 32'd1);
    checkOutput("ss_count_pending", {16'd0, capture_count}, 32'd0);
    mon_armed = 1'b0;
    tick();
    checkOutput("ss_idle", {28'd0, seq_state}, 32'd0);
    checkOutput("ss_sc_done_drop", {31'd0, mon_sc_done}, 32'd0);
    checkOutput("ss_count", {16'd0, capture_count}, 32'd1);
    checkOutput("ss_busy_end", {31'd0, busy}, 32'd0);

    // Trigger timeout at 100 cycles
    cfg_timeout = 24'd100;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    mon_armed = 1'b1;
    tick();
    repeat (99) tick();
    checkOutput("to_last_wait", {28'd0, seq_state}, 32'd3);
    tick();
    mon_armed = 1'b0;
    checkOutput("to_clear", {28'd0, seq_state}, 32'd9);
    checkOutput("to_clear_l", {31'd0, mon_clear_l}, 32'd0);
    checkOutput("to_flag", {31'd0, timeout_flag}, 32'd1);
    repeat (3) tick();
    checkOutput("to_clear_l_4th", {31'd0, mon_clear_l}, 32'd0);
    tick();
    checkOutput("to_clear_l_rel", {31'd0, mon_clear_l}, 32'd1);
    checkOutput("to_clear_tail", {28'd0, seq_state}, 32'd9);
    tick();
    checkOutput("to_idle", {28'd0, seq_state}, 32'd0);
    checkOutput("to_flag_sticky", {31'd0, timeout_flag}, 32'd1);
    checkOutput("to_count", {16'd0, capture_count}, 32'd1);

    // Trigger and timeout in the same cycle
    cfg_timeout = 24'd50;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    checkOutput("race_flag_clr", {31'd0, timeout_flag}, 32'd0);
    tick();
    mon_armed = 1'b1;
    tick();
    repeat (49) tick();
    mon_triggered = 1'b1;
    tick();
    mon_triggered = 1'b0;
    checkOutput("race_state", {28'd0, seq_state}, 32'd4);
    checkOutput("race_flag", {31'd0, timeout_flag}, 32'd0);

    // Abort during SEND
    mon_sc_run = 1'b1;
    tick();
    mon_sc_run = 1'b0;
    tick();
    checkOutput("ab_send", {28'd0, seq_state}, 32'd6);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    mon_armed = 1'b0;
    checkOutput("ab_clear", {28'd0, seq_state}, 32'd9);
    checkOutput("ab_clear_l", {31'd0, mon_clear_l}, 32'd0);
    cmd_start = 1'b1;
    snd_done = 1'b1;
    tick();
    cmd_start = 1'b0;
    snd_done = 1'b0;
    checkOutput("ab_start_ign", {28'd0, seq_state}, 32'd9);
    checkOutput("ab_no_sc_done", {31'd0, mon_sc_done}, 32'd0);
    repeat (3) tick();
    checkOutput("ab_clear_l_rel", {31'd0, mon_clear_l}, 32'd1);
    tick();
    checkOutput("ab_idle", {28'd0, seq_state}, 32'd0);
    checkOutput("ab_count", {16'd0, capture_count}, 32'd1);
    checkOutput("ab_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset in WAIT_TRIG
    cfg_timeout = 24'd0;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    tick();
    mon_armed = 1'b1;
    tick();
    checkOutput("ar_wait_trig", {28'd0, seq_state}, 32'd3);
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("ar_state", {28'd0, seq_state}, 32'd0);
    checkOutput("ar_busy", {31'd0, busy}, 32'd0);
    checkOutput("ar_clear_l", {31'd0, mon_clear_l}, 32'd1);
    checkOutput("ar_count", {16'd0, capture_count}, 32'd0);
    mon_armed = 1'b0;
    tick();
    rst_l = 1'b1;
    tick();
    checkOutput("ar_no_clear", {31'd0, mon_clear_l}, 32'd1);

    // Continuous mode, holdoff 8, continuous dropped before third completion
    cfg_holdoff = 16'd8;
    cmd_continuous = 1'b1;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    for (int n = 1; n <= 2; n++) begin
      applyStimulus();
      checkOutput("cont_holdoff", {28'd0, seq_state}, 32'd8);
      checkOutput("cont_count", {16'd0, capture_count}, n);
      repeat (8) tick();
      checkOutput("cont_hold_run0", {31'd0, mon_run}, 32'd0);
      tick();
      checkOutput("cont_rerun", {31'd0, mon_run}, 32'd1);
      checkOutput("cont_run_state", {28'd0, seq_state}, 32'd1);
    end
    cmd_continuous = 1'b0;
    applyStimulus();
    checkOutput("cont_final_idle", {28'd0, seq_state}, 32'd0);
    checkOutput("cont_final_count", {16'd0, capture_count}, 32'd3);
    checkOutput("cont_final_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
